// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: state and flag types shared by the run sequencer and its cells
package run_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_FILL, WAIT_LOAD, RUN, STOP} runSeqStateType;
    typedef struct packed {
        logic done;
        logic aborted;
        logic timed_out;
        logic pending;
        logic fill_seen;
        logic load_seen;
    } runSeqFlagsType;
endpackage

// File: rtl/dff.sv
// dff: register of any packed type, synchronously cleared to zero
module dff #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  T     i_d,
    output T     o_q
);
    always_ff @(posedge clk) o_q <= rst ? T'(0) : i_d;
endmodule

// File: rtl/run_watchdog.sv
// run_watchdog: counts write-free enabled cycles; expires in the cycle the count reaches the limit
module run_watchdog #(
    parameter int timeoutWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic                    i_kick,
    input  logic [timeoutWidth-1:0] i_limit,
    output logic                    o_expired
);
    logic [timeoutWidth-1:0] r_count, w_count_nxt;
    assign w_count_nxt = i_clear ? '0 : !i_enable ? r_count : i_kick ? '0 : r_count + 1'b1;
    assign o_expired   = i_enable && (r_count + 1'b1 == i_limit);
    dff #(.T(logic [timeoutWidth-1:0])) u_count (.clk(clk), .rst(rst), .i_d(w_count_nxt), .o_q(r_count));
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: launches the array fsm, counts result batches, stops it on completion, abort or watchdog
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int words         = 2,
    parameter int addressWidth  = $clog2(words),
    parameter int runCountWidth = 16,
    parameter int timeoutWidth  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfgValid,
    output logic                     cfgReady,
    input  logic [runCountWidth-1:0] cfgRuns,
    input  logic [timeoutWidth-1:0]  cfgTimeout,
    input  logic                     abort,
    output logic                     fsmStart,
    output logic                     fsmInterrupt,
    input  logic                     fsmFillingInputMemories,
    input  logic                     fsmLoadingWeights,
    input  logic                     fsmWxyzWriteEnable,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     timedOut,
    output logic [runCountWidth-1:0] runsCompleted
);
    runSeqStateType           r_state, w_state_nxt;
    runSeqFlagsType           r_flags, w_flags_nxt;
    logic [runCountWidth-1:0] r_runs, w_runs_nxt, r_completed, w_completed_nxt;
    logic [timeoutWidth-1:0]  r_timeout, w_timeout_nxt;
    logic [addressWidth-1:0]  r_word, w_word_nxt;
    logic                     w_accept, w_count, w_wrap, w_expired;

    assign cfgReady        = r_state == IDLE;
    assign w_accept        = cfgValid && cfgReady;
    assign w_count         = fsmWxyzWriteEnable && (r_state == WAIT_LOAD || r_state == RUN);
    assign w_wrap          = w_count && r_word == addressWidth'(words - 1);
    assign w_word_nxt      = (w_accept || w_wrap) ? '0 : w_count ? r_word + 1'b1 : r_word;
    assign w_completed_nxt = w_accept ? '0 : (w_wrap && ~&r_completed) ? r_completed + 1'b1 : r_completed;
    assign w_runs_nxt      = w_accept ? cfgRuns : r_runs;
    assign w_timeout_nxt   = w_accept ? cfgTimeout : r_timeout;

    run_watchdog #(.timeoutWidth(timeoutWidth)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_enable (r_state == RUN && r_timeout != '0),
        .i_kick   (fsmWxyzWriteEnable),
        .i_limit  (r_timeout),
        .o_expired(w_expired)
    );

    // the fsm ignores interrupt until running, so early aborts wait for RUN
    always_comb begin
        w_state_nxt         = r_state;
        w_flags_nxt         = r_flags;
        w_flags_nxt.done    = 1'b0;
        w_flags_nxt.pending = r_flags.pending || (abort && r_state != IDLE);
        case (r_state)
            IDLE: if (cfgValid) begin
                w_flags_nxt      = '0;
                w_flags_nxt.done = cfgRuns == '0;
                w_state_nxt      = cfgRuns == '0 ? IDLE : START;
            end
            START: w_state_nxt = WAIT_FILL;
            WAIT_FILL: begin
                w_flags_nxt.fill_seen = r_flags.fill_seen || fsmFillingInputMemories;
                w_state_nxt           = (r_flags.fill_seen && !fsmFillingInputMemories) ? WAIT_LOAD : WAIT_FILL;
            end
            WAIT_LOAD: begin
                w_flags_nxt.load_seen = r_flags.load_seen || fsmLoadingWeights;
                w_state_nxt           = (r_flags.load_seen && !fsmLoadingWeights) ? RUN : WAIT_LOAD;
            end
            RUN: begin
                if (w_completed_nxt >= r_runs) begin
                    w_state_nxt = STOP;
                end else if (abort || r_flags.pending) begin
                    w_state_nxt         = STOP;
                    w_flags_nxt.aborted = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt           = STOP;
                    w_flags_nxt.timed_out = 1'b1;
                end
            end
            STOP: begin
                w_state_nxt      = IDLE;
                w_flags_nxt.done = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    dff #(.T(runSeqStateType))            u_state    (.clk(clk), .rst(rst), .i_d(w_state_nxt),     .o_q(r_state));
    dff #(.T(runSeqFlagsType))            u_flags    (.clk(clk), .rst(rst), .i_d(w_flags_nxt),     .o_q(r_flags));
    dff #(.T(logic [runCountWidth-1:0])) u_runs     (.clk(clk), .rst(rst), .i_d(w_runs_nxt),      .o_q(r_runs));
    dff #(.T(logic [runCountWidth-1:0])) u_complete (.clk(clk), .rst(rst), .i_d(w_completed_nxt), .o_q(r_completed));
    dff #(.T(logic [timeoutWidth-1:0]))  u_timeout  (.clk(clk), .rst(rst), .i_d(w_timeout_nxt),   .o_q(r_timeout));
    dff #(.T(logic [addressWidth-1:0]))  u_word     (.clk(clk), .rst(rst), .i_d(w_word_nxt),      .o_q(r_word));

    assign fsmStart      = r_state == START;
    assign fsmInterrupt  = r_state == STOP;
    assign busy          = !cfgReady;
    assign done          = r_flags.done;
    assign aborted       = r_flags.aborted;
    assign timedOut      = r_flags.timed_out;
    assign runsCompleted = r_completed;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed timelines plus random traffic, checked every cycle against a job-level model
module tb_run_sequencer;
    localparam int WORDS = 2;

    logic        clk = 0, rst = 1, cfgValid = 0, abort = 0, fill = 0, load = 0, we = 0;
    logic [15:0] cfgRuns = 0, cfgTimeout = 0;
    logic        cfgReady, fsmStart, fsmInterrupt, busy, done, aborted, timedOut;
    logic [15:0] runsCompleted;

    run_sequencer #(.words(WORDS)) dut (
        .clk(clk), .rst(rst), .cfgValid(cfgValid), .cfgReady(cfgReady), .cfgRuns(cfgRuns),
        .cfgTimeout(cfgTimeout), .abort(abort), .fsmStart(fsmStart), .fsmInterrupt(fsmInterrupt),
        .fsmFillingInputMemories(fill), .fsmLoadingWeights(load), .fsmWxyzWriteEnable(we),
        .busy(busy), .done(done), .aborted(aborted), .timedOut(timedOut), .runsCompleted(runsCompleted)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, n_start = 0, n_int = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // job model: phase 0 idle,1 start,2 fill,3 load,4 run,5 stop; batches = total writes / WORDS
    int m_ph = 0, m_writes = 0, m_runs = 0, m_to = 0, m_idle = 0;
    bit m_pend = 0, m_fill = 0, m_load = 0, m_done = 0, m_ab = 0, m_tof = 0, m_nd, m_exp;

    function automatic int m_comp();
        return (m_writes / WORDS > 65535) ? 65535 : m_writes / WORDS;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_writes = 0; m_runs = 0; m_to = 0; m_idle = 0;
            m_pend = 0; m_fill = 0; m_load = 0; m_done = 0; m_ab = 0; m_tof = 0;
        end else begin
            m_nd = 0;
            if (m_ph != 0 && abort) m_pend = 1;
            case (m_ph)
                0: if (cfgValid) begin
                    m_runs = cfgRuns; m_to = cfgTimeout; m_writes = 0; m_idle = 0;
                    m_pend = 0; m_fill = 0; m_load = 0; m_ab = 0; m_tof = 0;
                    if (cfgRuns == 0) m_nd = 1; else m_ph = 1;
                end
                1: m_ph = 2;
                2: begin
                    if (m_fill && !fill) m_ph = 3;
                    m_fill |= fill;
                end
                3: begin
                    if (we) m_writes++;
                    if (m_load && !load) m_ph = 4;
                    m_load |= load;
                end
                4: begin
                    m_exp = m_to != 0 && m_idle + 1 == m_to;
                    m_idle = we ? 0 : m_idle + 1;
                    if (we) m_writes++;
                    if (m_comp() >= m_runs) m_ph = 5;
                    else if (abort || m_pend) begin m_ph = 5; m_ab = 1; end
                    else if (m_exp) begin m_ph = 5; m_tof = 1; end
                end
                default: begin m_ph = 0; m_nd = 1; end
            endcase
            m_done = m_nd;
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("cfgReady", cfgReady, m_ph == 0);
        check("busy", busy, m_ph != 0);
        check("fsmStart", fsmStart, m_ph == 1);
        check("fsmInterrupt", fsmInterrupt, m_ph == 5);
        check("done", done, m_done);
        check("aborted", aborted, m_ab);
        check("timedOut", timedOut, m_tof);
        check("runsCompleted", runsCompleted, m_comp());
        n_start += int'(fsmStart);
        n_int += int'(fsmInterrupt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int r, input int t);
        cfgValid = 1; cfgRuns = 16'(r); cfgTimeout = 16'(t);
        tick();
        cfgValid = 0;
    endtask

    task automatic to_run();
        fill = 1; tick(); tick();
        fill = 0; tick();
        load = 1; tick();
        load = 0; tick();
    endtask

    int s0, i0;

    initial begin
        tick(); chk_on = 1; tick(); rst = 0;
        check("rst_ready", cfgReady, 1);
        check("rst_busy", busy, 0);
        check("rst_runs", runsCompleted, 0);
        // zero-run job: done next cycle, nothing launched
        s0 = n_start; i0 = n_int;
        launch(0, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_start", fsmStart, 0);
        tick();
        check("zero_done_drop", done, 0);
        check("zero_no_pulses", n_start - s0 + n_int - i0, 0);
        // three batches, no watchdog
        s0 = n_start; i0 = n_int;
        launch(3, 0);
        check("job_start", fsmStart, 1);
        check("job_busy", busy, 1);
        to_run();
        for (int k = 0; k < 6; k++) begin
            we = 1; tick(); we = 0;
            if (k < 5) tick();
        end
        check("job_int_w1", fsmInterrupt, 1);
        check("job_done_w1", done, 0);
        tick();
        check("job_done_w2", done, 1);
        check("job_busy_w2", busy, 0);
        check("job_runs", runsCompleted, 3);
        check("job_flags", {aborted, timedOut}, 0);
        tick();
        check("job_one_start", n_start - s0, 1);
        check("job_one_int", n_int - i0, 1);
        // abort held from WAIT_FILL: deferred until RUN entry
        launch(2, 0);
        fill = 1; abort = 1; tick(); tick();
        fill = 0; tick();
        load = 1; tick();
        load = 0; tick();
        check("abort_no_int_run", fsmInterrupt, 0);
        tick();
        check("abort_int", fsmInterrupt, 1);
        abort = 0; tick();
        check("abort_done", done, 1);
        check("abort_flag", aborted, 1);
        check("abort_runs", runsCompleted, 0);
        // watchdog: five write-free cycles after the last write, then STOP
        launch(2, 5);
        to_run();
        we = 1; tick(); we = 0;
        repeat (4) tick();
        check("to_no_int_l5", fsmInterrupt, 0);
        tick();
        check("to_int_l6", fsmInterrupt, 1);
        tick();
        check("to_done", done, 1);
        check("to_flag", timedOut, 1);
        check("to_aborted", aborted, 0);
        // final write, abort and watchdog expiry coincide: completion wins
        launch(1, 3);
        to_run();
        we = 1; tick(); we = 0; tick(); tick();
        we = 1; abort = 1; tick();
        we = 0; abort = 0;
        check("prio_int", fsmInterrupt, 1);
        tick();
        check("prio_done", done, 1);
        check("prio_flags", {aborted, timedOut}, 0);
        check("prio_runs", runsCompleted, 1);
        // reset mid-RUN, then a clean job
        i0 = n_int;
        launch(2, 0);
        to_run();
        we = 1; tick(); we = 0;
        rst = 1; tick(); rst = 0;
        check("mid_rst_ready", cfgReady, 1);
        check("mid_rst_runs", runsCompleted, 0);
        check("mid_rst_outs", {fsmInterrupt, fsmStart, done, busy}, 0);
        check("mid_rst_no_int", n_int - i0, 0);
        launch(1, 0);
        check("clean_start", fsmStart, 1);
        to_run();
        we = 1; tick(); tick(); we = 0;
        check("clean_int", fsmInterrupt, 1);
        tick();
        check("clean_done", done, 1);
        check("clean_runs", runsCompleted, 1);
        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = $urandom_range(0, 299) == 0;
            cfgValid = $urandom_range(0, 3) == 0;
            cfgRuns = 16'($urandom_range(0, 4));
            cfgTimeout = $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(1, 6));
            abort = $urandom_range(0, 29) == 0;
            fill = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            tick();
        end
        {rst, cfgValid, abort, fill, load, we} = '0;
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
